sword_shift_rx: RTL

- Serial-to-parallel receiver for the Sword board's 3-wire display shift protocol (serial clock, serial data, latch/pen), the same protocol that drives the 7-seg and LED shift-register chains.
- Oversamples the three lines in the system clock domain, shifts data MSB-first and presents a parallel frame on each latch edge.
- Used as a board-model checker in simulation and as a loopback/readback port for the display driver.

---
 rtl/sword_shift_rx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sword_shift_rx.sv
// Serial-to-parallel receiver for the Sword 3-wire display shift protocol (sclk/sdat/pen).
// Define SHIFT_RX_CLR_EN to add the clr_n_i chain-clear input; without it the clear never asserts.
module sword_shift_rx #(
    parameter int FRAME_BITS = 64,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef SHIFT_RX_CLR_EN
    input  logic                  clr_n_i,
`endif
    input  logic                  sclk_i,
    input  logic                  sdat_i,
    input  logic                  pen_i,
    output logic [FRAME_BITS-1:0] data_o,
    output logic                  frame_valid_o,
    output logic                  frame_err_o,
    output logic [CNT_W-1:0]      bit_cnt_o,
    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   sreg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    sclk_p0, sclk_p1, sclk_p2;
    logic                    pen_p0, pen_p1, pen_p2;
    logic                    sdat_p0, sdat_p1;
    logic                    sclk_rise, pen_rise, clr_act;
    logic [FRAME_BITS-1:0]   sreg_next;

    // The counter sticks one past a full frame so any overlong frame still reads as bad.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_SAT) ? CNT_SAT : cnt + CNT_W'(1);
    endfunction

    // Stage p0/p1: two-flop synchronizers; p2: previous value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            pen_p0  <= 1'b0;
            pen_p1  <= 1'b0;
            pen_p2  <= 1'b0;
            sdat_p0 <= 1'b0;
            sdat_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk_i;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            pen_p0  <= pen_i;
            pen_p1  <= pen_p0;
            pen_p2  <= pen_p1;
            sdat_p0 <= sdat_i;
            sdat_p1 <= sdat_p0;
        end
    end

`ifdef SHIFT_RX_CLR_EN
    logic clr_n_p0, clr_n_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_n_p0 <= 1'b0;
            clr_n_p1 <= 1'b0;
        end else begin
            clr_n_p0 <= clr_n_i;
            clr_n_p1 <= clr_n_p0;
        end
    end

    assign clr_act = ~clr_n_p1;
`else
    assign clr_act = 1'b0;
`endif

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign pen_rise  = pen_p1 & ~pen_p2;
    // sdat shares the sclk synchronizer depth, so sdat_p1 is the value at the sclk rise
    assign sreg_next = {sreg[FRAME_BITS-2:0], sdat_p1};

    // Stage p3: frame FSM with registered pulses and output frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sreg          <= '0;
            bit_cnt       <= '0;
            data_o        <= '0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            if (clr_act) begin
                state   <= IDLE;
                sreg    <= '0;
                bit_cnt <= '0;
                if (pen_rise) begin
                    frame_err_o <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE, SHIFT: begin
                        if (sclk_rise) begin
                            sreg    <= sreg_next;
                            bit_cnt <= sat_inc(bit_cnt);
                        end
                        // A coincident sclk rise is absorbed above before the latch evaluates
                        if (pen_rise) begin
                            state <= LATCH;
                        end else if (sclk_rise) begin
                            state <= SHIFT;
                        end
                    end
                    LATCH: begin
                        if (bit_cnt == CNT_FULL) begin
                            data_o        <= sreg;
                            frame_valid_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                        // An sclk rise here is the first bit of the next frame
                        if (sclk_rise) begin
                            sreg    <= sreg_next;
                            bit_cnt <= CNT_W'(1);
                            state   <= SHIFT;
                        end else begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bit_cnt_o = bit_cnt;
    assign busy_o    = (state == SHIFT);

endmodule
